pf_lanectrl_pause_gen: RTL and testbench

PF_LANECTRL_PAUSE_GEN -- requirements
Module: pf_lanectrl_pause_gen

---
 rtl/pf_lanectrl_pkg.sv | 25 ++
 rtl/pf_lanectrl_pause_gen.sv | 172 +++++++++++++++++
 tb/tb_pf_lanectrl_pause_gen.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pf_lanectrl_pkg.sv
// ---------------------------------------------------------------------------
// pf_lanectrl_pkg
// Shared definitions for the lane-controller pause/update sequencer:
//   - state_t       : sequencer state encoding
//   - DEF_SETUP_CYC : default pause cycles ahead of the update strobe
//   - DEF_HOLD_CYC  : default pause cycles after the update strobe
//   - DEF_GAP_CYC   : default minimum pause-low cycles between sequences
//   - CNT_W         : width of the shared down-counter
// ---------------------------------------------------------------------------
package pf_lanectrl_pkg;

    localparam int unsigned CNT_W         = 4;
    localparam int unsigned DEF_SETUP_CYC = 4;
    localparam int unsigned DEF_HOLD_CYC  = 4;
    localparam int unsigned DEF_GAP_CYC   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_UPDT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/pf_lanectrl_pause_gen.sv
// ---------------------------------------------------------------------------
// pf_lanectrl_pause_gen
// Generates one pause/update sequence per request for a lane controller:
// the pause level is raised, after SETUP_CYC cycles a single-cycle update
// strobe is issued, the pause is held for HOLD_CYC more cycles, and then a
// pause-low gap of GAP_CYC cycles separates it from the next sequence.
// One extra request may be queued while a sequence runs; further requests
// are dropped and flagged.
//
// Ports:
//   CLK             in   clock, rising edge
//   RESET           in   synchronous active-high reset
//   REQ             in   single-cycle sequence request
//   ACK             out  single-cycle pulse on the first gap cycle
//   BUSY            out  high while any sequence state is active
//   HS_IO_CLK_PAUSE out  registered pause level to the pause synchronizer
//   UPDATE          out  registered single-cycle update strobe
//   OVERFLOW        out  sticky dropped-request flag
// ---------------------------------------------------------------------------
module pf_lanectrl_pause_gen
    import pf_lanectrl_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
    parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
    input  logic CLK,
    input  logic RESET,
    input  logic REQ,
    output logic ACK,
    output logic BUSY,
    output logic HS_IO_CLK_PAUSE,
    output logic UPDATE,
    output logic OVERFLOW
);

    // The counter is 4 bits wide, so each interval must fit in 1..15.
    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_badSetup
        $error("pf_lanectrl_pause_gen: SETUP_CYC must be in 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_badHold
        $error("pf_lanectrl_pause_gen: HOLD_CYC must be in 1..15");
    end
    if (GAP_CYC < 1 || GAP_CYC > 15) begin : g_badGap
        $error("pf_lanectrl_pause_gen: GAP_CYC must be in 1..15");
    end

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_pending;
    logic               r_overflow;
    logic               r_pause;
    logic               r_update;
    logic               r_ack;

    state_t             w_nextState;
    logic [CNT_W-1:0]   w_nextCount;
    logic               w_nextPending;
    logic               w_nextOverflow;
    logic               w_cntZero;
    logic               w_lastGap;
    logic               w_reqTakenDirect;
    logic               w_nextPause;

    // Next-state logic. A request arriving in the final gap cycle with no
    // queued request is taken straight into SETUP, so it must not also be
    // recorded as pending. Any other request during a sequence is queued
    // once; a second one while the queue is full is dropped.
    always_comb begin
        w_nextState      = r_state;
        w_nextCount      = r_count;
        w_nextPending    = r_pending;
        w_nextOverflow   = r_overflow;
        w_cntZero        = (r_count == '0);
        w_lastGap        = (r_state == ST_GAP) && w_cntZero;
        w_reqTakenDirect = w_lastGap && !r_pending;

        if (REQ && (r_state != ST_IDLE) && !w_reqTakenDirect) begin
            if (r_pending) begin
                w_nextOverflow = 1'b1;
            end else begin
                w_nextPending = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (REQ) begin
                    w_nextState = ST_SETUP;
                    w_nextCount = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (w_cntZero) begin
                    w_nextState = ST_UPDT;
                end else begin
                    w_nextCount = r_count - 1'b1;
                end
            end
            ST_UPDT: begin
                w_nextState = ST_HOLD;
                w_nextCount = HOLD_LOAD;
            end
            ST_HOLD: begin
                if (w_cntZero) begin
                    w_nextState = ST_GAP;
                    w_nextCount = GAP_LOAD;
                end else begin
                    w_nextCount = r_count - 1'b1;
                end
            end
            ST_GAP: begin
                if (w_cntZero) begin
                    if (r_pending) begin
                        w_nextState   = ST_SETUP;
                        w_nextCount   = SETUP_LOAD;
                        w_nextPending = 1'b0;
                    end else if (REQ) begin
                        w_nextState = ST_SETUP;
                        w_nextCount = SETUP_LOAD;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end else begin
                    w_nextCount = r_count - 1'b1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextCount = '0;
            end
        endcase

        w_nextPause = (w_nextState == ST_SETUP) ||
                      (w_nextState == ST_UPDT)  ||
                      (w_nextState == ST_HOLD);
    end

    // State, counter and flags. Outputs are registered from the next state
    // so that they line up with the state they describe while still coming
    // straight from a flop, which keeps the pause level glitch-free.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
            r_pause    <= 1'b0;
            r_update   <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_count    <= w_nextCount;
            r_pending  <= w_nextPending;
            r_overflow <= w_nextOverflow;
            r_pause    <= w_nextPause;
            r_update   <= (w_nextState == ST_UPDT);
            r_ack      <= (w_nextState == ST_GAP) && (r_state != ST_GAP);
        end
    end

    assign HS_IO_CLK_PAUSE = r_pause;
    assign UPDATE          = r_update;
    assign ACK             = r_ack;
    assign OVERFLOW        = r_overflow;
    assign BUSY            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pf_lanectrl_pause_gen.sv
// ---------------------------------------------------------------------------
// tb_pf_lanectrl_pause_gen
// Drives a default-parameter instance and a minimum-parameter (1/1/1)
// instance from the same REQ/RESET stimulus. A timeline model predicts every
// output each cycle from the offset into the running sequence; directed
// scenarios additionally pin both the model and the DUTs to hand-derived
// cycle numbers.
// ---------------------------------------------------------------------------
module tb_pf_lanectrl_pause_gen;

    localparam int SP [2] = '{4, 1};
    localparam int HP [2] = '{4, 1};
    localparam int GP [2] = '{2, 1};

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    logic REQ   = 1'b0;

    logic pause0, upd0, ack0, busy0, ovf0;
    logic pause1, upd1, ack1, busy1, ovf1;

    int checks   = 0;
    int failures = 0;

    pf_lanectrl_pause_gen dut0 (
        .CLK             (CLK),
        .RESET           (RESET),
        .REQ             (REQ),
        .ACK             (ack0),
        .BUSY            (busy0),
        .HS_IO_CLK_PAUSE (pause0),
        .UPDATE          (upd0),
        .OVERFLOW        (ovf0)
    );

    pf_lanectrl_pause_gen #(
        .SETUP_CYC (1),
        .HOLD_CYC  (1),
        .GAP_CYC   (1)
    ) dut1 (
        .CLK             (CLK),
        .RESET           (RESET),
        .REQ             (REQ),
        .ACK             (ack1),
        .BUSY            (busy1),
        .HS_IO_CLK_PAUSE (pause1),
        .UPDATE          (upd1),
        .OVERFLOW        (ovf1)
    );

    always #5 CLK = ~CLK;

    // Output vector layout: bit0 pause, bit1 update, bit2 ack, bit3 busy,
    // bit4 overflow.
    function automatic logic [4:0] dutVec(input int m);
        if (m == 0) return {ovf0, busy0, ack0, upd0, pause0};
        else        return {ovf1, busy1, ack1, upd1, pause1};
    endfunction

    // Timeline model: a running sequence is described only by the cycle in
    // which its pause starts; every output is a function of the offset from
    // that cycle. mCyc is the number of the cycle currently in progress.
    bit         mActive  [2];
    bit         mPending [2];
    bit         mOvf     [2];
    int         mStart   [2];
    logic [4:0] mExp     [2];
    int         mCyc = 0;
    bit         cmpEn = 1'b0;

    always @(posedge CLK) begin
        for (int m = 0; m < 2; m++) begin
            int k;
            int lastGap;
            lastGap = mStart[m] + SP[m] + HP[m] + GP[m];
            if (RESET) begin
                mActive[m]  = 1'b0;
                mPending[m] = 1'b0;
                mOvf[m]     = 1'b0;
            end else if (!mActive[m]) begin
                if (REQ) begin
                    mActive[m] = 1'b1;
                    mStart[m]  = mCyc + 1;
                end
            end else if (mCyc == lastGap) begin
                if (mPending[m]) begin
                    mStart[m]   = mCyc + 1;
                    mPending[m] = 1'b0;
                    if (REQ) mOvf[m] = 1'b1;
                end else if (REQ) begin
                    mStart[m] = mCyc + 1;
                end else begin
                    mActive[m] = 1'b0;
                end
            end else if (REQ) begin
                if (mPending[m]) mOvf[m] = 1'b1;
                else             mPending[m] = 1'b1;
            end
            k = mCyc + 1 - mStart[m];
            mExp[m] = {mOvf[m],
                       mActive[m],
                       mActive[m] && (k == SP[m] + HP[m] + 1),
                       mActive[m] && (k == SP[m]),
                       mActive[m] && (k <= SP[m] + HP[m])};
        end
        mCyc++;
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge CLK) begin
        if (cmpEn) begin
            for (int m = 0; m < 2; m++) begin
                logic [4:0] got;
                got = dutVec(m);
                checks++;
                if (got !== mExp[m]) begin
                    failures++;
                    $display("[TB] FAIL model_cmp dut%0d cycle %0d: got %b expected %b (ovf,busy,ack,upd,pause)",
                             m, mCyc, got, mExp[m]);
                end
            end
        end
    end

    // Per-scenario traces, one 64-bit cycle mask per DUT and signal.
    logic [63:0] trD [2][5];
    logic [63:0] trM [2][5];
    int          scenLen;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Resets both DUTs, then plays reqMask/rstMask cycle by cycle starting
    // at scenario cycle 0, recording DUT and model outputs per cycle.
    task automatic applyStimulus(input logic [63:0] reqMask,
                                 input logic [63:0] rstMask,
                                 input int n);
        logic [4:0] d;
        RESET = 1'b1;
        REQ   = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #2;
        scenLen = n;
        for (int m = 0; m < 2; m++)
            for (int s = 0; s < 5; s++) begin
                trD[m][s] = '0;
                trM[m][s] = '0;
            end
        for (int c = 0; c < n; c++) begin
            REQ   = reqMask[c];
            RESET = rstMask[c];
            @(negedge CLK);
            for (int m = 0; m < 2; m++) begin
                d = dutVec(m);
                for (int s = 0; s < 5; s++) begin
                    trD[m][s][c] = d[s];
                    trM[m][s][c] = mExp[m][s];
                end
            end
            @(posedge CLK);
            #2;
        end
        REQ   = 1'b0;
        RESET = 1'b0;
    endtask

    // Compares the recorded DUT trace and model trace of one signal against
    // a hand-derived cycle mask.
    task automatic checkOutput(input string name, input int m, input int s,
                               input logic [63:0] expMask);
        logic [63:0] win;
        win = rng(0, scenLen - 1);
        checks++;
        if ((trD[m][s] & win) !== expMask) begin
            failures++;
            $display("[TB] FAIL %s dut%0d: got %h expected %h", name, m, trD[m][s] & win, expMask);
        end
        checks++;
        if ((trM[m][s] & win) !== expMask) begin
            failures++;
            $display("[TB] FAIL %s model%0d: got %h expected %h", name, m, trM[m][s] & win, expMask);
        end
    endtask

    initial begin
        @(posedge CLK);
        cmpEn = 1'b1;

        // Single request with defaults, and the 1/1/1 boundary instance.
        applyStimulus(rng(0, 0), '0, 16);
        checkOutput("single_pause",  0, 0, rng(1, 9));
        checkOutput("single_update", 0, 1, rng(5, 5));
        checkOutput("single_ack",    0, 2, rng(10, 10));
        checkOutput("single_busy",   0, 3, rng(1, 11));
        checkOutput("single_ovf",    0, 4, '0);
        checkOutput("min_pause",     1, 0, rng(1, 3));
        checkOutput("min_update",    1, 1, rng(2, 2));
        checkOutput("min_ack",       1, 2, rng(4, 4));
        checkOutput("min_busy",      1, 3, rng(1, 4));

        // Queued second request: back-to-back with no idle cycle.
        applyStimulus(rng(0, 0) | rng(3, 3), '0, 26);
        checkOutput("queued_pause",  0, 0, rng(1, 9) | rng(12, 20));
        checkOutput("queued_update", 0, 1, rng(5, 5) | rng(16, 16));
        checkOutput("queued_ack",    0, 2, rng(10, 10) | rng(21, 21));
        checkOutput("queued_busy",   0, 3, rng(1, 22));
        checkOutput("queued_ovf",    0, 4, '0);

        // Third request while one is already queued is dropped.
        applyStimulus(rng(0, 0) | rng(2, 2) | rng(4, 4), '0, 26);
        checkOutput("ovf_ack",   0, 2, rng(10, 10) | rng(21, 21));
        checkOutput("ovf_flag",  0, 4, rng(5, 25));
        checkOutput("ovf_pause", 0, 0, rng(1, 9) | rng(12, 20));

        // Reset mid-sequence, then a fresh request.
        applyStimulus(rng(0, 0) | rng(6, 6), rng(3, 3), 20);
        checkOutput("rst_pause",  0, 0, rng(1, 3) | rng(7, 15));
        checkOutput("rst_update", 0, 1, rng(11, 11));
        checkOutput("rst_ack",    0, 2, rng(16, 16));
        checkOutput("rst_busy",   0, 3, rng(1, 3) | rng(7, 17));

        // Request and reset together: nothing starts.
        applyStimulus(rng(0, 0), rng(0, 0), 8);
        for (int s = 0; s < 5; s++) begin
            checkOutput("reqrst_dut0", 0, s, '0);
            checkOutput("reqrst_dut1", 1, s, '0);
        end

        repeat (2) @(posedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
